// File: rtl/pump_duty_scheduler_if.sv
// Handshake bundle between the tank supervisor and the pump duty scheduler:
// level/enable/fault inputs and the registered pump run commands.
interface pump_duty_scheduler_if;
  logic enable;
  logic demand;
  logic high_level;
  logic fault1;
  logic fault2;
  logic pump1;
  logic pump2;
  logic last;
  logic alarm;

  modport master (
    output enable, demand, high_level, fault1, fault2,
    input  pump1, pump2, last, alarm
  );

  modport slave (
    input  enable, demand, high_level, fault1, fault2,
    output pump1, pump2, last, alarm
  );
endinterface

// File: rtl/pump_duty_scheduler.sv
// Two-pump lead/lag scheduler: alternates the lead pump per demand, holds a
// minimum run and a post-run rest, adds an assist pump on high level, fails over on faults.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | both pumps off, waiting for enable & demand
// ST_RUN    | single pump on (pump selected by sel), min-on timer counting
// ST_ASSIST | both pumps on while high level persists
// ST_REST   | both pumps held off for REST cycles after a normal stop
module pump_duty_scheduler #(
  parameter int unsigned MIN_ON = 8,
  parameter int unsigned REST   = 4,
  parameter int unsigned CW     = 8
) (
  input logic clk,
  input logic rst,
  pump_duty_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_ASSIST = 2'd2,
    ST_REST   = 2'd3
  } state_t;

  localparam logic [CW-1:0] MIN_ON_LAST = CW'(MIN_ON - 1);
  localparam logic [CW-1:0] REST_LAST   = CW'(REST - 1);
  localparam logic [CW-1:0] TIMER_MAX   = '1;

  state_t        state, state_nxt;
  logic          sel, sel_nxt;
  logic          last, last_nxt;
  logic [CW-1:0] timer, timer_nxt;
  logic [CW-1:0] timer_inc;
  logic          pump1, pump2, alarm;
  logic          pump1_nxt, pump2_nxt, alarm_nxt;
  logic          sel_fault, other_fault, lead_fault, lag_fault;

  assign timer_inc = (timer == TIMER_MAX) ? timer : timer + CW'(1);

  assign sel_fault   = sel  ? bus.fault2 : bus.fault1;
  assign other_fault = sel  ? bus.fault1 : bus.fault2;
  // The lead pump for a new demand is the one that did not finish the last run.
  assign lead_fault  = last ? bus.fault1 : bus.fault2;
  assign lag_fault   = last ? bus.fault2 : bus.fault1;

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    last_nxt  = last;
    timer_nxt = timer;

    case (state)
      ST_IDLE: begin
        timer_nxt = '0;
        if (bus.enable && bus.demand) begin
          if (!lead_fault) begin
            state_nxt = ST_RUN;
            sel_nxt   = ~last;
          end else if (!lag_fault) begin
            state_nxt = ST_RUN;
            sel_nxt   = last;
          end
        end
      end

      ST_RUN: begin
        if (!bus.enable) begin
          state_nxt = ST_IDLE;
          timer_nxt = '0;
        end else if (sel_fault) begin
          timer_nxt = '0;
          if (!other_fault) begin
            sel_nxt = ~sel;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (bus.high_level && !other_fault) begin
          state_nxt = ST_ASSIST;
          timer_nxt = timer_inc;
        end else if (!bus.demand && (timer >= MIN_ON_LAST)) begin
          state_nxt = ST_REST;
          timer_nxt = '0;
          last_nxt  = sel;
        end else begin
          timer_nxt = timer_inc;
        end
      end

      ST_ASSIST: begin
        if (!bus.enable || (bus.fault1 && bus.fault2)) begin
          state_nxt = ST_IDLE;
          timer_nxt = '0;
        end else if (bus.fault1) begin
          state_nxt = ST_RUN;
          sel_nxt   = 1'b1;
          timer_nxt = '0;
        end else if (bus.fault2) begin
          state_nxt = ST_RUN;
          sel_nxt   = 1'b0;
          timer_nxt = '0;
        end else if (!bus.high_level) begin
          state_nxt = ST_RUN;
          timer_nxt = timer_inc;
        end else begin
          timer_nxt = timer_inc;
        end
      end

      ST_REST: begin
        if (timer == REST_LAST) begin
          state_nxt = ST_IDLE;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer_inc;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        timer_nxt = '0;
      end
    endcase

    // Outputs follow the next state so they change on the transition edge.
    pump1_nxt = (state_nxt == ST_ASSIST) || ((state_nxt == ST_RUN) && !sel_nxt);
    pump2_nxt = (state_nxt == ST_ASSIST) || ((state_nxt == ST_RUN) &&  sel_nxt);
    alarm_nxt = bus.enable & bus.demand & bus.fault1 & bus.fault2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      sel   <= 1'b0;
      last  <= 1'b1;
      timer <= '0;
      pump1 <= 1'b0;
      pump2 <= 1'b0;
      alarm <= 1'b0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      last  <= last_nxt;
      timer <= timer_nxt;
      pump1 <= pump1_nxt;
      pump2 <= pump2_nxt;
      alarm <= alarm_nxt;
    end
  end

  assign bus.pump1 = pump1;
  assign bus.pump2 = pump2;
  assign bus.last  = last;
  assign bus.alarm = alarm;

endmodule

// File: doc/pump_duty_scheduler.md
# pump_duty_scheduler

Scheduler that shares two pumps (B1, B2) between successive demand cycles of a single tank. It alternates the lead pump on each demand, enforces a minimum run time and a post-run rest period, brings in the second pump as assist on a high-level condition, and fails over to the healthy pump on a fault. It sits above the alternating two-pump output stage and replaces its ad-hoc toggle with a clocked, timed state machine.

## Interface
- MIN_ON, 8: minimum cycles a pump stays commanded on once started (≥1)
- REST, 4: cycles both pumps are held off after a normal stop (≥1)
- CW, 8: timer width; MIN_ON and REST must be < 2^CW
- Clock  in  1  system clock, rising edge active
- R  in  1  reset, asynchronous, active-high
- I  in  1  enable; 0 forces both pumps off immediately
- S  in  1  demand (level above start point)
- H  in  1  high-level condition requesting assist
- F1  in  1  pump 1 fault (1 = unavailable)
- F2  in  1  pump 2 fault (1 = unavailable)
- B1  out  1  pump 1 run command, registered
- B2  out  1  pump 2 run command, registered
- Last  out  1  pump that completed the last normal run (0 = pump 1, 1 = pump 2), registered
- Alarm  out  1  demand present but no healthy pump, registered

## Operation
- States: IDLE, RUN (single pump, selected by internal Sel), ASSIST (both pumps), REST.
- Reset: state IDLE, Sel=0, Last=1 (first run uses pump 1), timer=0, B1=B2=0, Alarm=0.
- IDLE: on I&S, pick ~Last if that pump is healthy, else the other pump. If at least one pump is healthy, go to RUN with timer=0. If both are faulted, stay in IDLE.
- RUN: checks in priority order.
  1. ~I → IDLE.
  2. Selected pump faulted: other pump healthy → stay RUN with Sel flipped and timer=0; otherwise → IDLE.
  3. H and other pump healthy → ASSIST.
  4. ~S and timer ≥ MIN_ON-1 → REST with timer=0 and Last=Sel.
  5. Otherwise stay in RUN and increment timer (saturating).
- ASSIST: B1=B2=1. Checks in priority order.
  1. ~I → IDLE.
  2. One pump faulted → RUN on the healthy pump, timer=0. Both faulted → IDLE.
  3. ~H → RUN on Sel, timer continues.
  4. Otherwise stay in ASSIST; timer increments, saturating.
- REST: B1=B2=0 and the timer increments. At the edge where timer==REST-1, go to IDLE. Inputs are ignored in REST, except that R still acts.
- Stops caused by I or fault exits bypass MIN_ON and REST and do not update Last.
- Alarm is recomputed every edge: Alarm = I & S & F1 & F2.
- Timer arithmetic is unsigned CW bits and saturates at 2^CW-1; it never wraps.

## Timing
- All inputs are sampled on the rising Clock edge. B1, B2, Last and Alarm are registered and change on the same edge as the state transition. Start latency is therefore 0 cycles after the sampling edge: S sampled high at edge k gives B high from edge k.
- Normal run: the pump stays high for at least MIN_ON cycles, then both pumps are low for exactly REST cycles. IDLE can then accept S on the following edge.
- Failover: the faulted pump's B drops and the other pump's B rises on the same edge, with no overlap gap and no double-on.
- Simultaneous events resolve by the priority order listed under Operation.
- R asserted mid-operation: B1, B2, Alarm, state and timer clear immediately (asynchronously), and Last returns to 1. After R deasserts, the next demand starts pump 1.

## Test plan
- Alternation: I=1, S pulses of 12 cycles separated by 10 cycles, three times. Required: B1 high 12 cycles, then B2 high 12 cycles, then B1 high 12 cycles. Last goes 0, 1, 0. Each run is followed by 4 off cycles.
- Minimum on: S high for 2 cycles only. Required: B1 high exactly 8 cycles, then 4 cycles REST, Last=0.
- Assist: pump 1 running, H=1 for 5 cycles. Required: B2 also high for those 5 cycles, then only B1 remains high while S=1.
- Failover and alarm: B1 running, F1 rises. Required: on the next edge B1=0 and B2=1. Then F2 rises with S=1. Required: B2=0 and Alarm=1. Alarm clears on the edge after S falls.
- Enable drop: I→0 at cycle 3 of a run. Required: B off on the next edge with no REST, Last unchanged. The next demand restarts the same lead pump.
- Async reset: R pulse mid-ASSIST, between clock edges. Required: B1=B2=0 immediately. After release, the next S starts pump 1.
